// File: rtl/range_stack_pkg.sv
// range_stack_pkg: shared constants and types for the range stack.
//   DATA_W_DEF  default width of each stored value
//   DEPTH_DEF   default capacity in pairs (power of two, >= 2)
//   pair_t      one {lo,hi} range at the default width; lo occupies the
//               upper half of the packed word, matching the storage layout.
package range_stack_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 32;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] lo;
        logic [DATA_W_DEF-1:0] hi;
    } pair_t;

endpackage

// File: rtl/range_stack_mem.sv
// range_stack_mem: pair storage for range_stack.
//   clk    write clock
//   we     write enable
//   waddr  write index
//   wdata  packed {lo,hi} pair to write
//   raddr  read index (asynchronous read)
//   rdata  packed {lo,hi} pair at raddr
// No reset: contents are undefined until written.
module range_stack_mem
    import range_stack_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * DATA_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/range_stack.sv
// range_stack: LIFO of {lo,hi} pairs (e.g. quicksort work ranges).
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous flush (count and err to 0), highest priority
//   push,val_lo/hi    store one pair
//   pop               remove the top pair into ret_lo/ret_hi
//   ret_lo/hi         registered popped pair, held until the next pop
//   ret_valid         one-cycle pulse, one cycle after an accepted pop
//   top_lo/hi         combinational peek of the top pair, 0 when empty
//   count             pairs stored
//   empty, full       registered, derived from the next count
//   err               sticky overflow/underflow flag
module range_stack
    import range_stack_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] val_lo,
    input  logic [DATA_W-1:0] val_hi,
    input  logic              pop,
    output logic [DATA_W-1:0] ret_lo,
    output logic [DATA_W-1:0] ret_hi,
    output logic              ret_valid,
    output logic [DATA_W-1:0] top_lo,
    output logic [DATA_W-1:0] top_hi,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam int unsigned IDX_W = CNT_W - 1;

    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_nxt;
    logic [CNT_W-1:0]    count_dec;
    logic [IDX_W-1:0]    top_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic                we;
    logic                ret_load;
    logic                ret_from_push;
    logic                err_set;
    logic                empty_q;
    logic                full_q;
    logic [2*DATA_W-1:0] rd_pair;

    assign count_dec = count_q - CNT_W'(1);
    assign top_idx   = count_dec[IDX_W-1:0];

    range_stack_mem #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_idx),
        .wdata ({val_lo, val_hi}),
        .raddr (top_idx),
        .rdata (rd_pair)
    );

    // Decode of clear > push/pop. Push+pop on a non-empty stack replaces the
    // top slot in place; on an empty stack it bypasses memory entirely.
    always_comb begin
        count_nxt     = count_q;
        we            = 1'b0;
        wr_idx        = count_q[IDX_W-1:0];
        ret_load      = 1'b0;
        ret_from_push = 1'b0;
        err_set       = 1'b0;
        if (clear) begin
            count_nxt = '0;
        end else if (push && pop) begin
            ret_load = 1'b1;
            if (empty_q) begin
                ret_from_push = 1'b1;
            end else begin
                we     = 1'b1;
                wr_idx = top_idx;
            end
        end else if (push) begin
            if (full_q) begin
                err_set = 1'b1;
            end else begin
                we        = 1'b1;
                count_nxt = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty_q) begin
                err_set = 1'b1;
            end else begin
                ret_load  = 1'b1;
                count_nxt = count_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            err       <= 1'b0;
            ret_valid <= 1'b0;
            ret_lo    <= '0;
            ret_hi    <= '0;
        end else begin
            count_q   <= count_nxt;
            empty_q   <= (count_nxt == '0);
            full_q    <= (count_nxt == CNT_W'(DEPTH));
            ret_valid <= ret_load;
            if (clear) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
            if (ret_load) begin
                if (ret_from_push) begin
                    ret_lo <= val_lo;
                    ret_hi <= val_hi;
                end else begin
                    ret_lo <= rd_pair[2*DATA_W-1:DATA_W];
                    ret_hi <= rd_pair[DATA_W-1:0];
                end
            end
        end
    end

    assign count  = count_q;
    assign empty  = empty_q;
    assign full   = full_q;
    assign top_lo = empty_q ? '0 : rd_pair[2*DATA_W-1:DATA_W];
    assign top_hi = empty_q ? '0 : rd_pair[DATA_W-1:0];

endmodule

// File: doc/range_stack.md
RANGE_STACK -- requirements
Module: range_stack

Interface
REQ-001 Parameter DATA_W, default 32, the width of each stored value.
REQ-002 Parameter DEPTH, default 32, the capacity in pairs; it SHALL be a power of two and at least 2.
REQ-003 Derived constant CNT_W = log2(DEPTH)+1, the width of the pair count.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 clear  in  1  synchronous flush; empties the stack and clears err.
REQ-007 push  in  1  request to store one pair {val_lo,val_hi}.
REQ-008 val_lo, val_hi  in  DATA_W each  pair to push (e.g. a quicksort lo/hi range).
REQ-009 pop  in  1  request to remove the top pair.
REQ-010 ret_lo, ret_hi  out  DATA_W each  popped pair, registered.
REQ-011 ret_valid  out  1  one-cycle pulse marking ret_lo/ret_hi as valid.
REQ-012 top_lo, top_hi  out  DATA_W each  combinational peek of the top pair; 0 when empty.
REQ-013 count  out  CNT_W  number of pairs currently stored.
REQ-014 empty, full  out  1 each  count==0 and count==DEPTH respectively, both registered.
REQ-015 err  out  1  sticky flag for overflow or underflow.

Function
REQ-016 Each accepted push SHALL write its pair at index count and raise count by 1 on the same clock edge.
REQ-017 Each accepted pop SHALL register the pair at index count-1 into ret_lo/ret_hi, pulse ret_valid on the next cycle, and lower count by 1.
REQ-018 Pop latency SHALL be exactly 1 cycle from the pop edge to ret_valid high; ret_lo/ret_hi SHALL hold their value until the next accepted pop.
REQ-019 Simultaneous push and pop on a non-empty stack SHALL return the old top pair, overwrite the top slot with the new pair, and leave count unchanged.
REQ-020 Simultaneous push and pop on an empty stack SHALL act as a pass-through: ret gets the pushed pair, ret_valid pulses, and count stays 0.
REQ-021 A push while full with no pop is an overflow: it SHALL be dropped, leave memory and count unchanged, and set err.
REQ-022 A pop while empty with no push is an underflow: ret_valid SHALL stay low, ret_lo/ret_hi SHALL keep their value, and err SHALL be set.
REQ-023 clear SHALL take priority over push and pop: count becomes 0, err becomes 0, ret_valid stays low, and memory contents are not cleared.
REQ-024 empty and full SHALL be updated from the next value of count in the same edge, so they are never one cycle stale.
REQ-025 Index arithmetic SHALL use log2(DEPTH) bits; count itself SHALL never exceed DEPTH or wrap below 0.
REQ-026 err SHALL be cleared only by reset or clear.

Reset
REQ-027 On rst_n low, asynchronously: count=0, empty=1, full=0, err=0, ret_valid=0, ret_lo=0, ret_hi=0.
REQ-028 Memory SHALL NOT be reset; top_lo/top_hi SHALL read 0 while empty regardless of memory contents.
REQ-029 A reset asserted mid-operation SHALL abandon any in-flight pop; no ret_valid pulse SHALL follow the release of reset.

Structure
REQ-030 Package range_stack_pkg SHALL hold the default DATA_W/DEPTH constants and a pair struct type {lo,hi}.
REQ-031 Pair storage SHALL be one sub-module, range_stack_mem: 2*DATA_W wide, DEPTH deep, one synchronous write port and one asynchronous read port, no reset.
REQ-032 The top level SHALL contain the count register, the flag logic, the ret registers and the priority logic clear > push/pop.

Verification
REQ-033 Push (1,10),(2,20),(3,30), then pop 3 times -> ret (3,30),(2,20),(1,10), each 1 cycle after its pop; empty=1 and count=0 at the end.
REQ-034 Push DEPTH pairs, then push again -> full=1, count=DEPTH, err=1, and the top is still pair DEPTH.
REQ-035 Pop from empty after reset -> ret_valid=0, ret=(0,0), err=1; then clear -> err=0.
REQ-036 With (5,6) stored, push (7,8) and pop in the same cycle -> ret (5,6), count=1, top (7,8).
REQ-037 Push and pop together on an empty stack with (9,9) -> ret (9,9), ret_valid=1, count=0, empty=1.
REQ-038 Push 4 pairs, then pulse rst_n low for half a cycle during a pop -> count=0, empty=1, and no ret_valid afterwards.
